// File: rtl/apb4_master_bridge.sv
// Valid/ready command/response to APB4 master bridge, one transfer in flight.
// Optional ACCESS-phase timeout is enabled with `define APB_TIMEOUT_EN.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_next;
  logic   done, abort;

  logic                    cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [DATA_WIDTH/8-1:0] pstrb_d;
  logic [2:0]              pprot_d;

  assign done = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      wait_cnt <= '0;
    else if (state == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !PREADY)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // Abort on the TIMEOUT_CYCLES-th consecutive wait; PREADY on that cycle wins.
  assign abort = (state == ACCESS) && !PREADY && (wait_cnt == LIMIT);
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (done || abort) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d   = (state_next == IDLE);
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    pprot_d       = PPROT;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          psel_d   = 1'b1;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (done) begin
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
        end else if (abort) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
      PPROT       <= pprot_d;
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed + randomized bench for apb4_master_bridge; the slave is emulated inline.
// Timeout cases are exercised when APB_TIMEOUT_EN is defined.
module tb_apb4_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK, PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;

  int tests = 0;
  int fails = 0;

  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_strb;
  logic [2:0]  e_prot;
  logic        e_write;

  apb4_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_apb(input string tag);
    chk({tag, "_paddr"},  PADDR, e_addr);
    chk({tag, "_pwrite"}, 32'(PWRITE), 32'(e_write));
    chk({tag, "_pwdata"}, PWDATA, e_wdata);
    chk({tag, "_pstrb"},  32'(PSTRB), 32'(e_strb));
    chk({tag, "_pprot"},  32'(PPROT), 32'(e_prot));
  endtask

  task automatic junk_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    cmd_prot  = 3'($urandom);
  endtask

  // One complete transfer; the upstream keeps a different command asserted while busy.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int waits,
                      input logic [31:0] rdata, input bit err, input int hold);
    bit          to;
    int          n_acc;
    logic [31:0] x_rdata;
    bit          x_err;
    to      = TO_EN && (waits >= T);
    n_acc   = to ? T : waits + 1;
    x_rdata = (to || wr) ? 32'h0 : rdata;
    x_err   = to ? 1'b1 : err;

    @(negedge PCLK);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_psel", 32'(PSEL), 32'd0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    @(negedge PCLK);
    e_addr = addr; e_write = wr; e_wdata = wdata; e_prot = prot;
    e_strb = wr ? strb : 4'h0;
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk_apb("setup");
    junk_cmd();
    @(negedge PCLK);
    for (int i = 0; i < n_acc; i++) begin
      chk("access_psel", 32'(PSEL), 32'd1);
      chk("access_penable", 32'(PENABLE), 32'd1);
      chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      chk_apb("access");
      if (!to && i == waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = err;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      junk_cmd();
      @(negedge PCLK);
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_psel", 32'(PSEL), 32'd0);
      chk("resp_penable", 32'(PENABLE), 32'd0);
      chk("resp_rdata", rsp_rdata, x_rdata);
      chk("resp_err", 32'(rsp_err), 32'(x_err));
      chk("resp_timeout", 32'(rsp_timeout), 32'(to));
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk_apb("resp");
      if (h < hold) begin
        rsp_ready = 1'b0;
        junk_cmd();
        PRDATA = $urandom; PSLVERR = 1'($urandom);
        @(negedge PCLK);
      end
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_rsp_err", 32'(rsp_err), 32'd0);
    chk("done_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_psel", 32'(PSEL), 32'd0);
    chk_apb("done");
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    PRESET = 1'b0;

    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'hA5A5_A5A5, 1'b0, 0);
    xfer(1'b0, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 3'd2, 3, 32'h1234_5678, 1'b0, 0);
    xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'd5, 1, 32'hCAFE_0001, 1'b1, 5);

    // rsp_ready while no response is pending must be ignored
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
      chk("idle_rsp_ready_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    rsp_ready = 1'b0;

    // reset during a wait-stated ACCESS
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h55; cmd_strb = 4'h3; cmd_prot = 3'd1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst_psel", 32'(PSEL), 32'd0);
    chk("async_rst_penable", 32'(PENABLE), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_paddr", PADDR, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    xfer(1'b0, 32'h0000_0048, 32'h0, 4'h0, 3'd0, 0, 32'h8765_4321, 1'b0, 1);

    if (TO_EN) begin
      xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd0, 12, 32'hFFFF_0000, 1'b0, 0);
      xfer(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'd0, T - 1, 32'h0F0F_0F0F, 1'b0, 0);
      xfer(1'b1, 32'h0000_0108, 32'h1111_2222, 4'h5, 3'd3, T, 32'h0, 1'b0, 2);
    end else begin
      xfer(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'd0, 20, 32'hFFFF_0000, 1'b0, 0);
    end

    for (int k = 0; k < 25; k++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           int'($urandom_range(TO_EN ? 6 : 5, 0)), $urandom, 1'($urandom),
           int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- Converts a simple valid/ready command/response interface into APB4 master transfers.
- Sits directly upstream of the APB4 slave and drives PSEL/PENABLE/PADDR/PWDATA/PSTRB/PPROT/PWRITE into it; collects PRDATA/PSLVERR back.
- Used as the RTL master that stimulates the APB4 slave environment, and as the host-side bridge in SoC integration.
- One transfer in flight at a time; no pipelining across transfers.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data; must be 8, 16 or 32.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN); range 1..255.

Ports:
- PCLK  in  1  single clock for all logic.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB4 control.
- PADDR  out  ADDR_WIDTH  APB4 address.
- PWDATA  out  DATA_WIDTH  APB4 write data.
- PSTRB  out  DATA_WIDTH/8  APB4 strobes.
- PPROT  out  3  APB4 protection.
- PREADY, PSLVERR  in  1 each  APB4 slave handshake and error.
- PRDATA  in  DATA_WIDTH  APB4 read data.

Behaviour:
- All state and outputs are registered. PRESET asynchronously clears every output to 0, except cmd_ready, which is 1 after reset. State returns to IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP. cmd_ready = (state == IDLE).
- IDLE: when cmd_valid && cmd_ready, capture the command into PADDR/PWRITE/PWDATA/PPROT.
  - PSTRB = cmd_strb for writes, all zeros for reads (APB4 rule).
  - Next cycle: SETUP with PSEL=1, PENABLE=0.
- SETUP: unconditionally go to ACCESS next cycle with PENABLE=1.
- ACCESS:
  - While PREADY=0: hold all APB outputs stable.
  - On PREADY=1: rsp_rdata = PRDATA for reads, 0 for writes; rsp_err = PSLVERR; rsp_timeout = 0.
  - Next cycle: PSEL=0, PENABLE=0, rsp_valid=1, state RESP.
- Latency: command accepted at cycle N -> PSEL at N+1 -> PENABLE at N+2 -> rsp_valid at N+3 with zero wait states. Each wait state adds 1 cycle.
- RESP: hold rsp_* stable until rsp_ready=1. On that cycle clear rsp_valid and rsp_err/rsp_timeout, then go to IDLE. Minimum command-to-command spacing is 4 cycles.
- rsp_ready asserted while rsp_valid=0 is ignored.
- After a transfer, PADDR/PWRITE/PWDATA/PSTRB/PPROT retain their last values; PSEL/PENABLE are 0.
- PSLVERR and PRDATA are sampled only in ACCESS with PREADY=1; ignored at all other times.
- cmd_valid while cmd_ready=0: command is not accepted; the upstream must hold it.
- PRESET mid-transfer (any state): outputs clear immediately. Any in-flight response is discarded and no partial response is issued.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0. If it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts:
  - Next cycle: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 arrives on the same cycle the limit is reached, the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- Write 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, PREADY=1 immediately -> PSEL at N+1, PENABLE at N+2, PSTRB=0xF; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read 0x0000_0020, slave returns 0x1234_5678 after 3 wait states -> PSTRB=0, APB outputs stable through waits; rsp_rdata=0x1234_5678 at N+6.
- Read with PSLVERR=1 at completion -> rsp_err=1, rsp_rdata=PRDATA; with rsp_ready held 0 for 5 cycles, response stays stable and cmd_ready stays 0.
- PRESET asserted during ACCESS with a wait-stated slave -> PSEL/PENABLE/rsp_valid drop asynchronously, cmd_ready=1 after release, and the next command completes normally.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th cycle -> normal completion, rsp_timeout=0.
